// File: rtl/ss_pkg.sv
// Shared types and sizing helpers for the shift-register sequencer.
package ss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Counter must reach DEPTH+WIDTH (+1 with parity) without wrapping.
  function automatic int cnt_w(input int depth, input int width);
    return $clog2(depth + width + 2);
  endfunction

endpackage

// File: rtl/ss_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a tie goes to the other one.
module ss_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       en,
  output logic [1:0] grant,
  output logic       update
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    update = |grant;
    last_d = update ? grant[1] : last_q;
  end

  // Reset value 1 means requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ss_shift_sequencer.sv
// Shares one serial shift register between two requesters: serialize LSB-first, flush, capture, respond.
// Define SS_SEQ_PARITY_EN to append an even-parity bit and report mismatches on rsp_err.
module ss_shift_sequencer
  import ss_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [1:0]       req_dir,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             sreg_in,
  output logic             sreg_lr,
  output logic             sreg_en,
  input  logic             sreg_out
);

`ifdef SS_SEQ_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = cnt_w(DEPTH, WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH + L - 1);

  state_e           state_q, state_d;
  logic [L-1:0]     word_q, word_d;
  logic [L-1:0]     cap_q, cap_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic             sreg_in_q, sreg_in_d;
  logic             sreg_lr_q, sreg_lr_d;
  logic             sreg_en_q, sreg_en_d;

  logic [1:0]       grant;
  logic             update;
  logic [WIDTH-1:0] sel_data;
  logic             sel_dir;
  logic [L-1:0]     sel_word;

  // Arbitration is blocked while reset is held so req_ready reads 0 in reset.
  ss_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .en        ((state_q == IDLE) && rst_n),
    .grant     (grant),
    .update    (update)
  );

  always_comb begin
    sel_data = grant[1] ? req_data1 : req_data0;
    sel_dir  = grant[1] ? req_dir[1] : req_dir[0];
`ifdef SS_SEQ_PARITY_EN
    sel_word = {^sel_data, sel_data};
`else
    sel_word = sel_data;
`endif
  end

  // Serial outputs are registered, so they are computed from the next counter value.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cap_d       = cap_q;
    dir_d       = dir_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    sreg_in_d   = 1'b0;
    sreg_lr_d   = 1'b0;
    sreg_en_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (update) begin
          state_d   = SHIFT;
          word_d    = sel_word;
          dir_d     = sel_dir;
          owner_d   = grant[1];
          cnt_d     = '0;
          sreg_en_d = 1'b1;
          sreg_lr_d = sel_dir;
          sreg_in_d = sel_word[0];
        end
      end
      SHIFT: begin
        for (int i = 0; i < L; i++) begin
          if (cnt_q == CW'(DEPTH + i)) cap_d[i] = sreg_out;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_data_d  = cap_d[WIDTH-1:0];
`ifdef SS_SEQ_PARITY_EN
          rsp_err_d   = cap_d[L-1] ^ (^cap_d[WIDTH-1:0]);
`else
          rsp_err_d   = 1'b0;
`endif
        end else begin
          sreg_en_d = 1'b1;
          sreg_lr_d = dir_q;
          for (int i = 0; i < L; i++) begin
            if (cnt_d == CW'(i)) sreg_in_d = word_q[i];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cap_q       <= '0;
      dir_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      sreg_in_q   <= 1'b0;
      sreg_lr_q   <= 1'b0;
      sreg_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cap_q       <= cap_d;
      dir_q       <= dir_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      sreg_in_q   <= sreg_in_d;
      sreg_lr_q   <= sreg_lr_d;
      sreg_en_q   <= sreg_en_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign sreg_in   = sreg_in_q;
  assign sreg_lr   = sreg_lr_q;
  assign sreg_en   = sreg_en_q;

endmodule

// File: doc/ss_shift_sequencer.md
Name: ss_shift_sequencer

Overview:
- Sequences and shares one serial-in/serial-out shift register (depth DEPTH, direction select, enable) between two requesters.
- Arbitration is round-robin. The block serializes each granted parallel word LSB-first into the register, then flushes it. It captures the bits emerging at the register output back into a parallel result and returns that result to the winner.
- Sits between the chip-level wrapper/host logic and the shift register instance. It drives the register's in, leftright and enable pins.

Parameters:
- WIDTH, 8, bits per transaction word (2..16).
- DEPTH, 8, shift-register stage count (latency in, to out) (1..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_data0  in  WIDTH  word from requester 0
- req_data1  in  WIDTH  word from requester 1
- req_dir  in  2  per-requester direction, passed to leftright
- rsp_valid  out  2  one-cycle pulse to the requester that owned the transaction
- rsp_data  out  WIDTH  captured word, shared, valid with rsp_valid
- rsp_err  out  1  parity error flag, valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- sreg_in  out  1  serial data to the shift register
- sreg_lr  out  1  direction to the shift register
- sreg_en  out  1  enable to the shift register
- sreg_out  in  1  serial data from the shift register

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready, rsp_valid, rsp_err, busy, sreg_in, sreg_lr and sreg_en all 0; rsp_data 0; round-robin pointer prefers requester 0.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, req_ready: combinational. Grant the only valid requester. If both are valid, grant the one not granted last.
  - A handshake (valid && ready) latches data, dir and owner id, sets cnt=0, updates the pointer to the owner, and moves to SHIFT.
- SHIFT: sreg_en=1 and sreg_lr=latched dir for the whole state. Let L=WIDTH (or WIDTH+1 with parity).
  - sreg_in = bit cnt of the latched word while cnt<L, else 0.
  - On cycles cnt=DEPTH..DEPTH+L-1, sample sreg_out into capture bit (cnt-DEPTH).
  - cnt increments each cycle. At cnt=DEPTH+L-1, go to DONE.
- DONE: sreg_en=0. rsp_valid[owner]=1 for exactly one cycle; rsp_data and rsp_err are held until the next DONE. Then go to IDLE.
- Latency: from the handshake cycle to rsp_valid = L+DEPTH+1 cycles. Back-to-back transactions need one idle cycle between them (the IDLE re-arbitration cycle).
- req_ready is 0 outside IDLE. Requests arriving during SHIFT/DONE wait; there is no queueing beyond req_valid being held.
- The counter is wide enough for DEPTH+WIDTH+1 with no wrap.
- The sequencer never inspects direction semantics; it only forwards dir to sreg_lr.
- rst_n asserted mid-transaction: immediate abort, no rsp_valid, outputs go to reset values. The shift register contents are don't-care afterwards.
- A requester dropping req_valid after the handshake has no effect on the transaction.

Optional Feature:
- Macro: SS_SEQ_PARITY_EN.
- Defined: L=WIDTH+1. An even-parity bit of the latched word is shifted after the data MSB. The captured parity bit is compared with the parity of the captured word, and rsp_err=1 on mismatch.
- Not defined: L=WIDTH and rsp_err is tied 0.

Decomposition:
- Shared package ss_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - default WIDTH/DEPTH constants;
  - counter-width function (clog2 of DEPTH+WIDTH+2).
- Sub-module ss_rr_arbiter: a 2-way round-robin arbiter with grant pointer. Inputs are req_valid and an enable (state==IDLE); outputs are grant and an update strobe.
- FSM, counter and capture logic stay in ss_shift_sequencer.

Test Plan (WIDTH=8, DEPTH=8; bench models the register as an 8-cycle delay line gated by sreg_en):
- Single request: req0 with data 0xA5, dir=0 -> sreg_en high 16 cycles, sreg_lr=0, rsp_valid[0] pulse 17 cycles after the handshake, rsp_data=0xA5, rsp_err=0.
- Contention: req0 and req1 both valid from reset (0x3C/0xC3) -> requester 0 served first, then requester 1; rsp_data 0x3C then 0xC3. With both held, grants alternate 0,1,0,1.
- Direction passthrough: req1 with dir=1, data 0x01 -> sreg_lr=1 throughout SHIFT, rsp_valid[1] only, rsp_data=0x01.
- Reset mid-SHIFT: assert rst_n low at cnt=5 -> busy=0 and sreg_en=0 immediately, no rsp_valid. The next request (0x5A) completes normally.
- Boundary: data 0x00 and 0xFF -> returned exactly. req_ready stays 0 while busy; a late req_valid is accepted only after DONE.
- SS_SEQ_PARITY_EN: data 0x07, bench flips the 9th captured bit -> 17+1-cycle shift, rsp_err=1. Without the flip, rsp_err=0.
